fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the RISC-V pipeline. Owns the program counter, drives the combinational byte-addressed instruction memory one aligned word per cycle, and buffers fetched {pc, instruction} pairs in a 2-entry queue toward IF/ID under a valid/ready handshake. Handles branch redirects with queue flush, stops cleanly at end of program, and traps misaligned targets.

## Interface
- IMEM_BYTES, 160: instruction memory size in bytes; PCs ≥ IMEM_BYTES are end of program
- RESET_PC, 64'd0: PC loaded on reset

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Inst_Address  output  64  word address to instruction memory (= current PC)
- Instruction  input  32  combinational instruction memory read data for Inst_Address
- redirect  input  1  taken branch/jump from EX; highest priority
- redirect_pc  input  64  redirect target
- out_valid  output  1  queue head holds a fetched instruction
- out_ready  input  1  IF/ID accepts head (pipeline not stalled)
- out_pc  output  64  PC of queue head
- out_instr  output  32  instruction at queue head
- halted  output  1  PC ran past IMEM_BYTES; fetching stopped
- fault  output  1  redirect target not 4-byte aligned; fetching stopped

## Operation
- State machine, states FETCH, HALT, FAULT. Reset → FETCH, PC = RESET_PC.
- FETCH: push {PC, Instruction} into queue and PC += 4 when queue can accept (count < 2, or count == 2 with a pop this cycle). Otherwise PC holds.
- FETCH → HALT when next PC (after increment) ≥ IMEM_BYTES; the last in-range word is still pushed. No access beyond IMEM_BYTES-4 is ever presented on Inst_Address in FETCH; in HALT/FAULT Inst_Address holds the last PC.
- HALT: no pushes; queue keeps draining via out_ready. halted = 1.
- Redirect (any state): queue flushed (count = 0), PC = redirect_pc, no push that cycle, any coincident pop discarded. Next state: FAULT if redirect_pc[1:0] ≠ 0; HALT if redirect_pc ≥ IMEM_BYTES; else FETCH. Redirect is the only exit from HALT/FAULT besides reset.
- FAULT: no pushes, fault = 1, queue empty.
- Queue: 2 entries, 1-bit read/write pointers wrapping, 2-bit count. Pop on out_valid & out_ready. Push and pop in same cycle at count 1 or 2 leave count unchanged.
- out_valid = (count ≠ 0); out_pc/out_instr = head entry; out_pc = 0, out_instr = 0 when empty.
- PC arithmetic is 64-bit unsigned, no wrap handling needed beyond the IMEM_BYTES bound.

## Timing
- Reset values: Inst_Address = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 0, halted = 0, fault = 0.
- Fetch latency: word addressed in cycle N appears at queue output in cycle N+1 (out_valid high first cycle after reset release).
- Steady state with out_ready held high: one instruction per cycle, no bubbles.
- out_ready low: queue fills in 2 cycles, then PC holds; resumes same cycle out_ready returns (push+pop).
- Redirect in cycle N: cycle N+1 out_valid = 0, Inst_Address = redirect_pc; first redirected instruction valid in N+2.
- halted/fault are registered state outputs, asserted the cycle after the transition.
- reset mid-operation overrides redirect and handshake: queue cleared, state FETCH, PC = RESET_PC next cycle.

## Structure
- Shared package fetch_pkg: state enum (FETCH, HALT, FAULT), 96-bit fetch-entry struct {pc[63:0], instr[31:0]}, INSTR_BYTES = 4 constant.
- One sub-module: fetch_queue — 2-entry FIFO of fetch entries with push, pop, flush, count, full/empty.
- Top contains PC register, state machine, push/pop/flush control.

## Test plan
- Reset, out_ready = 1, IMEM_BYTES = 160: out_pc 0,4,…,156 on consecutive cycles, one per cycle; halted = 1 after 156 pushed; out_valid drops after 156 consumed.
- out_ready low from cycle 3 for 5 cycles: count saturates at 2, Inst_Address frozen; on release, no instruction lost or duplicated.
- redirect to 0x5C while queue full and out_ready = 1: next cycle out_valid = 0, following cycle out_pc = 0x5C.
- redirect to 0x5E: fault = 1, out_valid stays 0; later redirect to 0x10 resumes with out_pc = 0x10, fault = 0.
- From HALT, redirect to 0x20: fetching resumes at 0x20; redirect to 200 instead leaves halted = 1, nothing pushed.
- reset asserted mid-stream with queue full: next cycle out_valid = 0, Inst_Address = RESET_PC, halted = fault = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry FIFO of {pc, instr} fetch entries
//   clk, reset          : clock, synchronous active-high reset
//   flush               : empties the queue; wins over push/pop
//   push, push_entry    : write an entry (accepted when not full, or full with pop)
//   pop                 : drop the head entry (ignored when empty)
//   head_entry          : current head, all zeros when empty
//   count, full, empty  : occupancy
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_entry = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and fetch FSM feeding IF/ID through a 2-entry queue
//   clk, reset             : clock, synchronous active-high reset
//   Inst_Address           : word address to instruction memory (current PC)
//   Instruction            : combinational memory read data for Inst_Address
//   redirect, redirect_pc  : taken branch/jump from EX, highest priority
//   out_valid/out_ready    : handshake toward IF/ID
//   out_pc, out_instr      : queue head
//   halted, fault          : end of program / misaligned redirect target
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] IMEM_BYTES = 64'd160,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted,
  output logic        fault
);

  fetch_state_e state, next_state;
  logic [63:0]  pc, pc_next, pc_inc;
  logic         push, pop;
  fetch_entry_t push_entry, head_entry;
  logic [1:0]   q_count;
  logic         q_full, q_empty;

  assign pc_inc = pc + 64'(INSTR_BYTES);

  // A redirect discards the head together with the rest of the queue, so it
  // must not also count as a pop.
  assign pop  = (q_count != 2'd0) & out_ready & ~redirect;
  assign push = (state == FETCH) & ~redirect & (~q_full | pop);

  assign push_entry.pc    = pc;
  assign push_entry.instr = Instruction;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= pc_next;
    end
  end

  always_comb begin
    next_state = state;
    pc_next    = pc;
    if (redirect) begin
      pc_next = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        next_state = FAULT;
      end else if (redirect_pc >= IMEM_BYTES) begin
        next_state = HALT;
      end else begin
        next_state = FETCH;
      end
    end else if (push) begin
      // The PC stays on the last in-range word so that nothing past the end
      // of memory is ever put on Inst_Address.
      if (pc_inc >= IMEM_BYTES) begin
        next_state = HALT;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign Inst_Address = pc;
  assign out_valid    = ~q_empty;
  assign out_pc       = head_entry.pc;
  assign out_instr    = head_entry.instr;
  assign halted       = (state == HALT);
  assign fault        = (state == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic        fault;

  int passed = 0;
  int total  = 0;

  fetch_sequencer #(
    .IMEM_BYTES (64'd160),
    .RESET_PC   (64'd0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Inst_Address (Inst_Address),
    .Instruction  (Instruction),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .halted       (halted),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5A5_0000;
  endfunction

  assign Instruction = mem_word(Inst_Address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = 64'd0; out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (Inst_Address !== 64'd0) $display("FAIL reset_addr got %h want 0", Inst_Address); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
    total++; if (out_pc !== 64'd0) $display("FAIL reset_pc got %h want 0", out_pc); else passed++;
    total++; if (out_instr !== 32'd0) $display("FAIL reset_instr got %h want 0", out_instr); else passed++;
    total++; if (halted !== 1'b0 || fault !== 1'b0) $display("FAIL reset_flags got %b%b want 00", halted, fault); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== mem_word(64'(4 * i))) begin
        $display("FAIL stream_head i=%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 i, out_valid, out_pc, out_instr, 64'(4 * i), mem_word(64'(4 * i)));
      end else passed++;
      if (i == 38) begin
        total++; if (halted !== 1'b0) $display("FAIL stream_early_halt got %b want 0", halted); else passed++;
      end
      if (i == 39) begin
        total++; if (halted !== 1'b1) $display("FAIL stream_halted got %b want 1", halted); else passed++;
      end
    end
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid); else passed++;
    total++; if (Inst_Address !== 64'd156) $display("FAIL stream_last_addr got %h want 9c", Inst_Address); else passed++;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_pc;
    exp_pc = 64'd0;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      tick();
      out_ready = !(c >= 3 && c <= 7);
      if (c >= 4 && c <= 7) begin
        total++;
        if (Inst_Address !== 64'd16 || out_pc !== 64'd8 || out_valid !== 1'b1) begin
          $display("FAIL bp_stall c=%0d got addr=%h pc=%h v=%b want addr=10 pc=8 v=1",
                   c, Inst_Address, out_pc, out_valid);
        end else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
          $display("FAIL bp_order c=%0d got pc=%h ins=%h want pc=%h ins=%h",
                   c, out_pc, out_instr, exp_pc, mem_word(exp_pc));
        end else passed++;
        exp_pc = exp_pc + 64'd4;
      end
    end
    total++; if (exp_pc !== 64'd36) $display("FAIL bp_count got %h want 24", exp_pc); else passed++;
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    total++; if (out_pc !== 64'd0 || Inst_Address !== 64'd8) $display("FAIL redir_full got pc=%h addr=%h want 0/8", out_pc, Inst_Address); else passed++;
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h5C;
    tick();
    redirect = 1'b0;
    total++; if (out_valid !== 1'b0 || Inst_Address !== 64'h5C) $display("FAIL redir_flush got v=%b addr=%h want 0/5c", out_valid, Inst_Address); else passed++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 64'h5C || out_instr !== mem_word(64'h5C))
      $display("FAIL redir_first got v=%b pc=%h ins=%h want 1/5c/%h", out_valid, out_pc, out_instr, mem_word(64'h5C));
    else passed++;
  endtask

  task automatic test_fault();
    redirect = 1'b1; redirect_pc = 64'h5E;
    tick();
    redirect = 1'b0;
    total++; if (fault !== 1'b1 || out_valid !== 1'b0) $display("FAIL fault_set got f=%b v=%b want 1/0", fault, out_valid); else passed++;
    repeat (3) tick();
    total++;
    if (fault !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b0 || Inst_Address !== 64'h5E)
      $display("FAIL fault_hold got f=%b v=%b h=%b addr=%h want 1/0/0/5e", fault, out_valid, halted, Inst_Address);
    else passed++;
    redirect = 1'b1; redirect_pc = 64'h10;
    tick();
    redirect = 1'b0;
    total++; if (fault !== 1'b0 || out_valid !== 1'b0 || Inst_Address !== 64'h10) $display("FAIL fault_exit got f=%b v=%b addr=%h want 0/0/10", fault, out_valid, Inst_Address); else passed++;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h10) $display("FAIL fault_resume got v=%b pc=%h want 1/10", out_valid, out_pc); else passed++;
  endtask

  task automatic test_halt_redirect();
    redirect = 1'b1; redirect_pc = 64'h98;
    tick();
    redirect = 1'b0;
    tick();
    total++; if (out_pc !== 64'h98 || halted !== 1'b0) $display("FAIL halt_pre got pc=%h h=%b want 98/0", out_pc, halted); else passed++;
    tick();
    total++; if (out_pc !== 64'h9C || halted !== 1'b1) $display("FAIL halt_enter got pc=%h h=%b want 9c/1", out_pc, halted); else passed++;
    tick();
    total++; if (out_valid !== 1'b0 || halted !== 1'b1) $display("FAIL halt_drain got v=%b h=%b want 0/1", out_valid, halted); else passed++;
    redirect = 1'b1; redirect_pc = 64'h20;
    tick();
    redirect = 1'b0;
    total++; if (halted !== 1'b0 || Inst_Address !== 64'h20) $display("FAIL halt_exit got h=%b addr=%h want 0/20", halted, Inst_Address); else passed++;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h20) $display("FAIL halt_resume got v=%b pc=%h want 1/20", out_valid, out_pc); else passed++;
    redirect = 1'b1; redirect_pc = 64'd200;
    tick();
    redirect = 1'b0;
    total++; if (halted !== 1'b1 || out_valid !== 1'b0) $display("FAIL halt_oob got h=%b v=%b want 1/0", halted, out_valid); else passed++;
    repeat (2) tick();
    total++; if (out_valid !== 1'b0 || Inst_Address !== 64'd200) $display("FAIL halt_oob_hold got v=%b addr=%h want 0/c8", out_valid, Inst_Address); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h20;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || Inst_Address !== 64'h28) $display("FAIL mid_full got v=%b addr=%h want 1/28", out_valid, Inst_Address); else passed++;
    reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h40; out_ready = 1'b1;
    tick();
    reset = 1'b0; redirect = 1'b0;
    total++;
    if (out_valid !== 1'b0 || Inst_Address !== 64'd0 || halted !== 1'b0 || fault !== 1'b0)
      $display("FAIL mid_reset got v=%b addr=%h h=%b f=%b want 0/0/0/0", out_valid, Inst_Address, halted, fault);
    else passed++;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'd0) $display("FAIL mid_restart got v=%b pc=%h want 1/0", out_valid, out_pc); else passed++;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 64'd0; out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_halt_redirect();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
